// File: rtl/ccff_pkg.sv
// ccff_pkg: shared types and constants for the configuration-chain loader.
//   state_e   : loader sequencing states
//   BYTE_W    : width of one bitstream byte from the host
//   CNT_W     : width of the bit counter and phase timer
//   CRC8_POLY : polynomial for the optional ccff_tail CRC (CCFF_TAIL_CRC_EN)
`timescale 1ns/1ps
package ccff_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam logic [7:0]  CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        FETCH,
        LO,
        HI,
        TAIL,
        DONE
    } state_e;

    // One MSB-first CRC-8 step, init 0x00, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// ccff_loader_if: byte-stream handshake from the host / boot ROM.
//   s_data  : bitstream byte, MSB shifted first
//   s_valid : s_data valid
//   s_ready : byte accepted when s_valid && s_ready
// master = host side, slave = loader side.
`timescale 1ns/1ps
interface ccff_loader_if;
    import ccff_pkg::*;

    logic [BYTE_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/ccff_phase_timer.sv
// ccff_phase_timer: down-counter timing the set and prog_clk phases.
//   clk, reset : system clock, async active-high reset
//   load       : reload the counter with load_val
//   load_val   : phase length minus one
//   phase_end  : high in the last cycle of the current phase
`timescale 1ns/1ps
module ccff_phase_timer
    import ccff_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             phase_end
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign phase_end = (count_q == '0);

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: shifts a host byte stream into the tt_openfpga_top
// configuration chain (ccff_head / prog_clk / set) and holds the fabric
// disabled until a complete load has finished.
//   clk, reset   : system clock, async active-high reset
//   start, abort : begin a load (ignored while busy) / terminate a load
//   s            : byte stream handshake (ccff_loader_if.slave)
//   ccff_head    : serial config data, prog_clk : shift clock, set : fabric set
//   ccff_tail    : serial return from the end of the chain
//   fabric_en    : user-logic enable, busy : load in progress
//   done/aborted : one-cycle completion / abort pulses
//   bit_count    : bits shifted in the current load
// Optional: define CCFF_TAIL_CRC_EN to add tail_crc[7:0], a CRC-8 over
// ccff_tail sampled at each HI-phase exit.
`timescale 1ns/1ps
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = 128,
    parameter int unsigned HALF_PER   = 2,
    parameter int unsigned SET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    ccff_loader_if.slave     s,
    output logic             ccff_head,
    output logic             prog_clk,
    output logic             set,
    input  logic             ccff_tail,
    output logic             fabric_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] bit_count
`ifdef CCFF_TAIL_CRC_EN
    ,
    output logic [7:0]       tail_crc
`endif
);

    localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PER - 1);
    localparam logic [CNT_W-1:0] SET_LOAD  = CNT_W'((SET_CYCLES > 0) ? SET_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] sreg_q, sreg_d;
    logic [3:0]        bits_left_q, bits_left_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic [CNT_W-1:0]  remain;
    logic              head_q, head_d;
    logic              prog_clk_q, prog_clk_d;
    logic              set_q, set_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              fabric_en_q, fabric_en_d;
    logic              timer_load, phase_end;
    logic [CNT_W-1:0]  timer_val;

    ccff_phase_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .load_val  (timer_val),
        .phase_end (phase_end)
    );

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        bit_count_d = bit_count_q;
        fabric_en_d = fabric_en_q;
        aborted_d   = 1'b0;
        remain      = CHAIN_CNT - bit_count_q;

        if (state_q != IDLE && abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_d     = (SET_CYCLES > 0) ? SET : FETCH;
                    bit_count_d = '0;
                    fabric_en_d = 1'b0;
                end
                SET:   if (phase_end) state_d = FETCH;
                FETCH: if (s.s_valid) begin
                    sreg_d      = s.s_data;
                    // Short final byte: only the remaining chain bits are valid.
                    bits_left_d = (remain >= CNT_W'(BYTE_W)) ? 4'(BYTE_W) : remain[3:0];
                    state_d     = LO;
                end
                LO:    if (phase_end) state_d = HI;
                HI:    if (phase_end) begin
                    bit_count_d = bit_count_q + CNT_W'(1);
                    sreg_d      = {sreg_q[BYTE_W-2:0], 1'b0};
                    bits_left_d = bits_left_q - 4'd1;
                    if (bit_count_d == CHAIN_CNT) state_d = TAIL;
                    else if (bits_left_d != '0)   state_d = LO;
                    else                          state_d = FETCH;
                end
                TAIL:  if (phase_end) state_d = DONE;
                DONE: begin
                    state_d     = IDLE;
                    fabric_en_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so prog_clk/set never glitch.
        head_d     = (state_d == LO || state_d == HI) ? sreg_d[BYTE_W-1] : 1'b0;
        prog_clk_d = (state_d == HI);
        set_d      = (state_d == SET);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);

        // Every timed phase is entered through a state change, so reload there.
        timer_load = (state_d != state_q);
        timer_val  = (state_d == SET) ? SET_LOAD : HALF_LOAD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bits_left_q <= '0;
            bit_count_q <= '0;
            head_q      <= 1'b0;
            prog_clk_q  <= 1'b0;
            set_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            fabric_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
            bit_count_q <= bit_count_d;
            head_q      <= head_d;
            prog_clk_q  <= prog_clk_d;
            set_q       <= set_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            fabric_en_q <= fabric_en_d;
        end
    end

    assign s.s_ready = (state_q == FETCH);
    assign ccff_head = head_q;
    assign prog_clk  = prog_clk_q;
    assign set       = set_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign fabric_en = fabric_en_q;
    assign bit_count = bit_count_q;

`ifdef CCFF_TAIL_CRC_EN
    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (state_q == IDLE && start) begin
            crc_d = '0;
        end else if (state_q == HI && phase_end && !abort) begin
            crc_d = crc8_step(crc_q, ccff_tail);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) crc_q <= '0;
        else       crc_q <= crc_d;
    end

    assign tail_crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Testbench for ccff_loader (CHAIN_LEN=12, HALF_PER=2, SET_CYCLES=4).
// Stimulus pushes expected bits / end events into queues; monitors pop and
// compare on prog_clk rising edges and on done/aborted pulses.
`timescale 1ns/1ps
module tb_ccff_loader;

    typedef struct packed {
        logic        is_abort;
        logic [15:0] count;
    } end_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ccff_head, prog_clk, set, ccff_tail;
    logic        fabric_en, busy, done, aborted;
    logic [15:0] bit_count;
`ifdef CCFF_TAIL_CRC_EN
    logic [7:0]  tail_crc;
`endif

    ccff_loader_if bus ();

    ccff_loader #(
        .CHAIN_LEN  (12),
        .HALF_PER   (2),
        .SET_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .s         (bus),
        .ccff_head (ccff_head),
        .prog_clk  (prog_clk),
        .set       (set),
        .ccff_tail (ccff_tail),
        .fabric_en (fabric_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .bit_count (bit_count)
`ifdef CCFF_TAIL_CRC_EN
        ,
        .tail_crc  (tail_crc)
`endif
    );

    always #5 clk = ~clk;

    // 12-bit fabric chain model: shifts ccff_head in on rising prog_clk.
    logic [11:0] chain = '0;
    always @(posedge prog_clk) chain <= {chain[10:0], ccff_head};
    assign ccff_tail = chain[11];

    logic exp_bits[$];
    end_t exp_end[$];
    end_t cur_end;
    int   checks = 0;
    int   failures = 0;
    int   end_events = 0;
    int   set_cycles = 0;
    int   rises = 0;
    logic prog_clk_prev = 1'b0;
    logic [7:0] model_crc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no event or an unexpected one, expected the scheduled event", name);
    endtask

    function automatic logic [7:0] crc_ref(input logic [11:0] bits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 11; i >= 0; i--) begin
            if (c[7] ^ bits[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Monitor: bits on prog_clk rising edges, end events on done/aborted.
    always @(negedge clk) begin
        if (reset) begin
            prog_clk_prev = 1'b0;
        end else begin
            if (set) set_cycles++;
            if (prog_clk && !prog_clk_prev) begin
                rises++;
                // tail is sampled by the DUT after the chain has shifted
                if (chain[11] ^ model_crc[7]) model_crc = {model_crc[6:0], 1'b0} ^ 8'h07;
                else                          model_crc = {model_crc[6:0], 1'b0};
                if (exp_bits.size() == 0) fail_now("unexpected_prog_clk_rise");
                else chk("ccff_head_bit", ccff_head, exp_bits.pop_front());
            end
            prog_clk_prev = prog_clk;
            if (done || aborted) begin
                end_events++;
                if (exp_end.size() == 0) begin
                    fail_now("unexpected_end_pulse");
                end else begin
                    cur_end = exp_end.pop_front();
                    chk("end_aborted", aborted, cur_end.is_abort);
                    chk("end_done", done, !cur_end.is_abort);
                    chk("end_bit_count", bit_count, cur_end.count);
                    if (cur_end.is_abort) begin
                        chk("abort_busy", busy, 0);
                        chk("abort_prog_clk", prog_clk, 0);
                        chk("abort_set", set, 0);
                        chk("abort_fabric_en", fabric_en, 0);
                    end else begin
                        chk("done_busy", busy, 1);
`ifdef CCFF_TAIL_CRC_EN
                        chk("done_tail_crc", tail_crc, model_crc);
`endif
                    end
                end
            end
        end
    end

    task automatic push_bits(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(v[11 - i]);
    endtask

    task automatic pulse_start(input logic fresh);
        @(negedge clk);
        start = 1'b1;
        if (fresh) begin
            model_crc = '0;
            set_cycles = 0;
            rises = 0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) fail_now("handshake_timeout");
        else @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic wait_end(input int target, input string name);
        int unsigned n;
        n = 0;
        while (end_events < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (end_events < target) fail_now(name);
    endtask

    task automatic full_load(input logic [7:0] b0, input logic [7:0] b1, input int target);
        push_bits({b0, b1[7:4]}, 12);
        exp_end.push_back('{is_abort: 1'b0, count: 16'd12});
        pulse_start(1'b1);
        send_byte(b0);
        send_byte(b1);
        wait_end(target, "load_done_timeout");
    endtask

    initial begin
        int unsigned n;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_prog_clk", prog_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fabric_en", fabric_en, 0);
        chk("rst_ccff_head", ccff_head, 0);
        chk("rst_set", set, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_count", bit_count, 0);
        reset = 1'b0;

        // s_valid without start is ignored
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            chk("idle_s_ready", bus.s_ready, 0);
            chk("idle_busy", busy, 0);
        end
        bus.s_valid = 1'b0;

        // Test 1: 0xA5, 0xC0 with a 10-cycle stall between bytes
        push_bits(12'hA5C, 12);
        exp_end.push_back('{is_abort: 1'b0, count: 16'd12});
        pulse_start(1'b1);
        chk("start_busy", busy, 1);
        chk("start_fabric_en", fabric_en, 0);
        chk("start_set", set, 1);
        send_byte(8'hA5);
        n = 0;
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) fail_now("stall_fetch_timeout");
        repeat (10) begin
            @(negedge clk);
            chk("stall_s_ready", bus.s_ready, 1);
            chk("stall_prog_clk", prog_clk, 0);
        end
        send_byte(8'hC0);
        wait_end(1, "t1_done_timeout");
        @(negedge clk);
        chk("t1_busy_after", busy, 0);
        chk("t1_fabric_en_after", fabric_en, 1);
        chk("t1_bit_count", bit_count, 12);
        chk("t1_set_cycles", set_cycles, 4);
        chk("t1_rises", rises, 12);
        chk("t1_bits_left", exp_bits.size(), 0);
        chk("t1_ccff_head_idle", ccff_head, 0);

        // Test 2: abort while bit 5 is on the line
        push_bits(12'hA50, 5);
        exp_end.push_back('{is_abort: 1'b1, count: 16'd5});
        pulse_start(1'b1);
        chk("t2_bit_count_cleared", bit_count, 0);
        send_byte(8'hA5);
        n = 0;
        while (bit_count != 16'd5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (bit_count != 16'd5) fail_now("t2_bit5_timeout");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_end(2, "t2_abort_timeout");
        repeat (3) @(negedge clk);
        chk("t2_bits_left", exp_bits.size(), 0);
        chk("t2_fabric_en_held", fabric_en, 0);
        chk("t2_bit_count_held", bit_count, 5);

        // Test 3: restart from bit 0, with a start pulse while busy
        push_bits(12'hA5C, 12);
        exp_end.push_back('{is_abort: 1'b0, count: 16'd12});
        pulse_start(1'b1);
        send_byte(8'hA5);
        pulse_start(1'b0);
        send_byte(8'hC0);
        wait_end(3, "t3_done_timeout");
        repeat (40) @(negedge clk);
        chk("t3_single_done", end_events, 3);
        chk("t3_rises", rises, 12);
        chk("t3_bits_left", exp_bits.size(), 0);
        chk("t3_fabric_en", fabric_en, 1);
        chk("t3_busy", busy, 0);

        // Test 4: asynchronous reset in the middle of a HI phase
        push_bits(12'hA5C, 12);
        pulse_start(1'b1);
        send_byte(8'hA5);
        n = 0;
        while (!prog_clk && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!prog_clk) fail_now("t4_hi_timeout");
        #1 reset = 1'b1;
        #1;
        chk("t4_async_prog_clk", prog_clk, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_fabric_en", fabric_en, 0);
        chk("t4_async_bit_count", bit_count, 0);
        exp_bits.delete();
        exp_end.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Test 5: load the same stream twice; the second load's tail data is
        // the first stream advanced by one position
        full_load(8'hA5, 8'hC0, 4);
        @(negedge clk);
        chk("t5_chain_contents", chain, 12'hA5C);
        full_load(8'hA5, 8'hC0, 5);
        @(negedge clk);
        chk("t5_chain_reload", chain, 12'hA5C);
        chk("t5_bit_count", bit_count, 12);
`ifdef CCFF_TAIL_CRC_EN
        chk("t5_tail_crc", tail_crc, crc_ref(12'h4B9));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
